traffic_conflict_monitor: RTL and testbench

- Independent safety checker on the lamp-drive side of the traffic controller.
- Samples the highway/farmway RYG lamp codes every cycle and checks them for:
  - invalid codes;
  - conflicting right-of-way;
  - short yellow intervals;
  - stuck non-rest phases.
- On the first violation it latches a fault and a fault code. The cabinet logic uses these to force flash mode. The fault stays latched until reset or an explicit clear.

---
 rtl/tlc_pkg.sv | 26 ++
 rtl/tlc_run_counter.sv | 36 +++
 rtl/traffic_conflict_monitor.sv | 179 +++++++++++++++++
 tb/tb_traffic_conflict_monitor.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared lamp encodings, fault codes and monitor state encoding for the
// traffic conflict monitor.
package tlc_pkg;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam logic [2:0] FLT_NONE      = 3'b000;
    localparam logic [2:0] FLT_INVALID   = 3'b001;
    localparam logic [2:0] FLT_CONFLICT  = 3'b010;
    localparam logic [2:0] FLT_SHORT_YEL = 3'b011;
    localparam logic [2:0] FLT_STUCK     = 3'b100;

    localparam int FLASH_HALF = 4;

    typedef enum logic {
        MON_MONITOR = 1'b0,
        MON_LATCHED = 1'b1
    } mon_state_e;

    function automatic logic isOneHot(input logic [2:0] code);
        return (code == LAMP_RED) || (code == LAMP_YEL) || (code == LAMP_GRN);
    endfunction

endpackage

// File: rtl/tlc_run_counter.sv
// Saturating run-length counter: sync reset to 0, restart loads 1 (or 0 when
// not enabled), otherwise counts up while enabled and holds at all-ones.
module tlc_run_counter #(
    parameter int DW = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          restart_i,
    input  logic          enable_i,
    output logic [DW-1:0] count_o
);

    localparam logic [DW-1:0] CNT_MAX = '1;

    logic [DW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (restart_i) begin
            count_d = enable_i ? DW'(1) : '0;
        end else if (enable_i && (count_q != CNT_MAX)) begin
            count_d = count_q + DW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Lamp-side safety checker: latches the first invalid/conflict/short-yellow/stuck
// fault until clear or reset. Define TLC_FLASH_OUT_EN for flashing-red lamp outputs.
module traffic_conflict_monitor
    import tlc_pkg::*;
#(
    parameter int MIN_YELLOW = 3,
    parameter int MAX_DWELL  = 32,
    parameter int DW         = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    highway,
    input  logic [2:0]    farmway,
    input  logic          clr,
    output logic          fault,
    output logic [2:0]    fault_code,
    output logic [DW-1:0] hw_yel_cnt
`ifdef TLC_FLASH_OUT_EN
    ,
    output logic [2:0]    hw_lamp,
    output logic [2:0]    fw_lamp
`endif
);

    localparam logic [DW-1:0] MIN_YEL_C  = DW'(MIN_YELLOW);
    localparam logic [DW-1:0] STUCK_AT_C = DW'(MAX_DWELL - 1);

    logic [2:0]    prevHw_q, prevFw_q;
    logic          histValid_q;
    logic [DW-1:0] hwYelCnt, fwYelCnt, dwellCnt;
    mon_state_e    state_q, state_d;
    logic          fault_q, fault_d;
    logic [2:0]    code_q, code_d;
    logic          clearDwell;
    logic          isRest, combChanged;
    logic          invalidDet, conflictDet, shortYelDet, stuckDet, anyFault;
    logic [2:0]    detCode;

    assign isRest      = (highway == LAMP_GRN) && (farmway == LAMP_RED);
    assign combChanged = {highway, farmway} != {prevHw_q, prevFw_q};
    assign invalidDet  = !isOneHot(highway) || !isOneHot(farmway);
    assign conflictDet = (highway != LAMP_RED) && (farmway != LAMP_RED);
    assign shortYelDet = histValid_q &&
        (((prevHw_q == LAMP_YEL) && (highway != LAMP_YEL) && (hwYelCnt < MIN_YEL_C)) ||
         ((prevFw_q == LAMP_YEL) && (farmway != LAMP_YEL) && (fwYelCnt < MIN_YEL_C)));
    // The dwell counter's next value is q+1 when the combination is unchanged.
    assign stuckDet    = histValid_q && !isRest && !combChanged && (dwellCnt >= STUCK_AT_C);
    assign anyFault    = invalidDet || conflictDet || shortYelDet || stuckDet;

    always_comb begin
        detCode = FLT_NONE;
        if (invalidDet) begin
            detCode = FLT_INVALID;
        end else if (conflictDet) begin
            detCode = FLT_CONFLICT;
        end else if (shortYelDet) begin
            detCode = FLT_SHORT_YEL;
        end else if (stuckDet) begin
            detCode = FLT_STUCK;
        end
    end

    tlc_run_counter #(.DW(DW)) u_hw_yel (
        .clk_i     (clk),
        .rst_i     (rst),
        .restart_i (highway != LAMP_YEL),
        .enable_i  (highway == LAMP_YEL),
        .count_o   (hwYelCnt)
    );

    tlc_run_counter #(.DW(DW)) u_fw_yel (
        .clk_i     (clk),
        .rst_i     (rst),
        .restart_i (farmway != LAMP_YEL),
        .enable_i  (farmway == LAMP_YEL),
        .count_o   (fwYelCnt)
    );

    tlc_run_counter #(.DW(DW)) u_dwell (
        .clk_i     (clk),
        .rst_i     (rst || clearDwell),
        .restart_i (!histValid_q || combChanged || isRest),
        .enable_i  (1'b1),
        .count_o   (dwellCnt)
    );

    always_comb begin
        state_d    = state_q;
        fault_d    = fault_q;
        code_d     = code_q;
        clearDwell = 1'b0;
        unique case (state_q)
            MON_MONITOR: begin
                if (anyFault) begin
                    fault_d = 1'b1;
                    code_d  = detCode;
                    state_d = MON_LATCHED;
                end
            end
            MON_LATCHED: begin
                // A violation arriving together with clr re-latches with its own code.
                if (clr && anyFault) begin
                    code_d = detCode;
                end else if (clr) begin
                    fault_d    = 1'b0;
                    code_d     = FLT_NONE;
                    state_d    = MON_MONITOR;
                    clearDwell = 1'b1;
                end
            end
            default: state_d = MON_MONITOR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MON_MONITOR;
            fault_q     <= 1'b0;
            code_q      <= FLT_NONE;
            prevHw_q    <= '0;
            prevFw_q    <= '0;
            histValid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fault_q     <= fault_d;
            code_q      <= code_d;
            prevHw_q    <= highway;
            prevFw_q    <= farmway;
            histValid_q <= 1'b1;
        end
    end

    assign fault      = fault_q;
    assign fault_code = code_q;
    assign hw_yel_cnt = hwYelCnt;

`ifdef TLC_FLASH_OUT_EN
    localparam logic [1:0] FLASH_LAST = 2'(FLASH_HALF - 1);

    logic [2:0] hwLamp_q, hwLamp_d, fwLamp_q, fwLamp_d;
    logic [1:0] flashCnt_q, flashCnt_d;

    // Flashing red starts lit on the latch edge and toggles every FLASH_HALF cycles.
    always_comb begin
        flashCnt_d = '0;
        hwLamp_d   = highway;
        fwLamp_d   = farmway;
        if (state_d == MON_LATCHED) begin
            if (state_q == MON_MONITOR) begin
                hwLamp_d = LAMP_RED;
                fwLamp_d = LAMP_RED;
            end else if (flashCnt_q == FLASH_LAST) begin
                hwLamp_d = hwLamp_q ^ LAMP_RED;
                fwLamp_d = fwLamp_q ^ LAMP_RED;
            end else begin
                flashCnt_d = flashCnt_q + 2'd1;
                hwLamp_d   = hwLamp_q;
                fwLamp_d   = fwLamp_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hwLamp_q   <= LAMP_RED;
            fwLamp_q   <= LAMP_RED;
            flashCnt_q <= '0;
        end else begin
            hwLamp_q   <= hwLamp_d;
            fwLamp_q   <= fwLamp_d;
            flashCnt_q <= flashCnt_d;
        end
    end

    assign hw_lamp = hwLamp_q;
    assign fw_lamp = fwLamp_q;
`endif

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed self-checking bench for traffic_conflict_monitor with hand-computed
// expected fault/fault_code/hw_yel_cnt values.
module tb_traffic_conflict_monitor;
    import tlc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [2:0] highway;
    logic [2:0] farmway;
    logic       fault;
    logic [2:0] fault_code;
    logic [5:0] hw_yel_cnt;
`ifdef TLC_FLASH_OUT_EN
    logic [2:0] hw_lamp;
    logic [2:0] fw_lamp;
`endif

    int testsRun  = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    traffic_conflict_monitor #(
        .MIN_YELLOW (3),
        .MAX_DWELL  (32),
        .DW         (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .highway    (highway),
        .farmway    (farmway),
        .clr        (clr),
        .fault      (fault),
        .fault_code (fault_code),
        .hw_yel_cnt (hw_yel_cnt)
`ifdef TLC_FLASH_OUT_EN
        ,
        .hw_lamp    (hw_lamp),
        .fw_lamp    (fw_lamp)
`endif
    );

    // Inputs change 1 time unit after the rising edge so outputs are sampled mid-cycle.
    task automatic applyStimulus(input logic [2:0] hw, input logic [2:0] fw,
                                 input logic clrIn, input logic rstIn);
        highway = hw;
        farmway = fw;
        clr     = clrIn;
        rst     = rstIn;
        @(posedge clk);
        #1;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic expFault, input logic [2:0] expCode);
        checkValue({tag, ".fault"}, 32'(fault), 32'(expFault));
        checkValue({tag, ".code"}, 32'(fault_code), 32'(expCode));
    endtask

    task automatic holdLegal(input logic [2:0] hw, input logic [2:0] fw, input int n,
                             input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(hw, fw, 1'b0, 1'b0);
            checkValue({tag, ".fault"}, 32'(fault), 32'd0);
        end
    endtask

    initial begin
        highway = LAMP_GRN;
        farmway = LAMP_RED;
        clr     = 1'b0;
        rst     = 1'b1;

        applyStimulus(LAMP_GRN, LAMP_RED, 1'b0, 1'b1);
        applyStimulus(LAMP_GRN, LAMP_RED, 1'b0, 1'b1);
        checkOutput("reset", 1'b0, FLT_NONE);
        checkValue("reset.hw_yel_cnt", 32'(hw_yel_cnt), 32'd0);

        holdLegal(LAMP_GRN, LAMP_RED, 40, "rest40");
        holdLegal(LAMP_YEL, LAMP_RED, 4, "hw_yel");
        checkValue("hw_yel_cnt4", 32'(hw_yel_cnt), 32'd4);
        holdLegal(LAMP_RED, LAMP_YEL, 4, "fw_yel");
        checkValue("hw_yel_cnt_zero", 32'(hw_yel_cnt), 32'd0);
        holdLegal(LAMP_RED, LAMP_GRN, 8, "fw_grn");
        holdLegal(LAMP_YEL, LAMP_RED, 4, "hw_yel2");
        holdLegal(LAMP_GRN, LAMP_RED, 3, "rest_again");
        checkOutput("legal_cycle", 1'b0, FLT_NONE);

        applyStimulus(LAMP_GRN, LAMP_GRN, 1'b0, 1'b0);
        checkOutput("conflict", 1'b1, FLT_CONFLICT);
        applyStimulus(LAMP_GRN, LAMP_RED, 1'b1, 1'b0);
        checkOutput("clr_legal", 1'b0, FLT_NONE);

        applyStimulus(3'b011, LAMP_GRN, 1'b0, 1'b0);
        checkOutput("invalid_over_conflict", 1'b1, FLT_INVALID);
        applyStimulus(LAMP_GRN, LAMP_RED, 1'b1, 1'b0);
        checkOutput("clr_after_invalid", 1'b0, FLT_NONE);

        holdLegal(LAMP_YEL, LAMP_RED, 3, "yel_exact_min");
        holdLegal(LAMP_RED, LAMP_RED, 2, "all_red");
        checkOutput("yel_min_ok", 1'b0, FLT_NONE);

        holdLegal(LAMP_YEL, LAMP_RED, 2, "yel_short");
        checkValue("hw_yel_cnt2", 32'(hw_yel_cnt), 32'd2);
        applyStimulus(LAMP_RED, LAMP_RED, 1'b0, 1'b0);
        checkOutput("short_yel", 1'b1, FLT_SHORT_YEL);
        applyStimulus(LAMP_GRN, LAMP_GRN, 1'b0, 1'b0);
        checkOutput("latched_frozen", 1'b1, FLT_SHORT_YEL);
        applyStimulus(LAMP_GRN, LAMP_GRN, 1'b1, 1'b0);
        checkOutput("clr_with_conflict", 1'b1, FLT_CONFLICT);
        applyStimulus(LAMP_GRN, LAMP_RED, 1'b1, 1'b0);
        checkOutput("clr_after_conflict", 1'b0, FLT_NONE);

        holdLegal(LAMP_RED, LAMP_GRN, 31, "dwell31");
        holdLegal(LAMP_GRN, LAMP_RED, 2, "dwell31_exit");
        checkOutput("dwell31_ok", 1'b0, FLT_NONE);
        holdLegal(LAMP_RED, LAMP_GRN, 31, "dwell32_pre");
        applyStimulus(LAMP_RED, LAMP_GRN, 1'b0, 1'b0);
        checkOutput("stuck", 1'b1, FLT_STUCK);

        applyStimulus(LAMP_YEL, LAMP_RED, 1'b0, 1'b0);
        applyStimulus(LAMP_YEL, LAMP_RED, 1'b0, 1'b0);
        checkValue("latched_yel_cnt", 32'(hw_yel_cnt), 32'd2);
        checkOutput("stuck_held", 1'b1, FLT_STUCK);
        applyStimulus(LAMP_YEL, LAMP_RED, 1'b0, 1'b1);
        checkOutput("rst_latched", 1'b0, FLT_NONE);
        checkValue("rst_latched.hw_yel_cnt", 32'(hw_yel_cnt), 32'd0);
        applyStimulus(LAMP_GRN, LAMP_RED, 1'b0, 1'b0);
        checkOutput("post_rst", 1'b0, FLT_NONE);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
